// File: rtl/asym_dpram_pkg.sv
// Shared constants and helpers for the asymmetric dual-port RAM.
package asym_dpram_pkg;

  // Same-port read-during-write behaviour.
  localparam int unsigned WM_WRITE_FIRST = 0;
  localparam int unsigned WM_READ_FIRST  = 1;
  localparam int unsigned WM_NO_CHANGE   = 2;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = unsigned'(i) + 1;
    end
    return r;
  endfunction

  // One-hot lane select; callers keep the low RATIO bits.
  function automatic logic [7:0] lane_onehot(input int unsigned lane);
    return 8'b1 << lane;
  endfunction

endpackage

// File: rtl/asym_dpram_port.sv
// One port's output path: WRITE_MODE selection per lane, ssr handling, and
// the optional second output stage enabled by ASYM_DPRAM_OUTREG_EN.
module asym_dpram_port
  import asym_dpram_pkg::*;
#(
  parameter int unsigned             DW         = 8,
  parameter int unsigned             LANES      = 1,
  parameter int unsigned             WRITE_MODE = WM_WRITE_FIRST,
  parameter logic [DW*LANES-1:0]     SRVAL      = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic                ssr,
  input  logic [LANES-1:0]    we,
  input  logic [DW*LANES-1:0] rdata,
  input  logic [DW*LANES-1:0] wdata,
  output logic [DW*LANES-1:0] dout
);

  localparam int unsigned W = DW * LANES;

`ifdef ASYM_DPRAM_OUTREG_EN
  localparam logic [W-1:0] S1_RST = '0;
`else
  localparam logic [W-1:0] S1_RST = SRVAL;
`endif

  logic [W-1:0] s1_d, s1_q;

  // Stage-1 next value: per-lane read-during-write choice, hold when disabled.
  always_comb begin
    s1_d = s1_q;
    if (en) begin
      for (int k = 0; k < LANES; k++) begin
        if (!we[k]) begin
          s1_d[k*DW +: DW] = rdata[k*DW +: DW];
        end else if (WRITE_MODE == WM_WRITE_FIRST) begin
          s1_d[k*DW +: DW] = wdata[k*DW +: DW];
        end else if (WRITE_MODE == WM_READ_FIRST) begin
          s1_d[k*DW +: DW] = rdata[k*DW +: DW];
        end
        // no-change: a written lane keeps its previous output
      end
`ifndef ASYM_DPRAM_OUTREG_EN
      if (ssr) s1_d = SRVAL;
`endif
    end
  end

  // Stage-1 output register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) s1_q <= S1_RST;
    else        s1_q <= s1_d;
  end

`ifdef ASYM_DPRAM_OUTREG_EN
  logic [W-1:0] s2_q;

  // Stage-2 output register; ssr acts here when the pipeline is enabled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_q <= SRVAL;
    end else if (en) begin
      s2_q <= ssr ? SRVAL : s1_q;
    end
  end

  assign dout = s2_q;
`else
  assign dout = s1_q;
`endif

endmodule

// File: rtl/asym_dpram.sv
// Single-clock true dual-port RAM: narrow port A (NW bits), wide port B
// (NW*RATIO bits, per-lane write enables). Port B wins same-lane write
// conflicts; a reader sees old data on cross-port conflicts, and such events
// are flagged on collision. ASYM_DPRAM_OUTREG_EN adds an output stage.
module asym_dpram
  import asym_dpram_pkg::*;
#(
  parameter int unsigned         NW         = 8,
  parameter int unsigned         RATIO      = 4,
  parameter int unsigned         NDEPTH     = 2048,
  parameter int unsigned         WRITE_MODE = WM_WRITE_FIRST,
  parameter logic [NW-1:0]       SRVAL_A    = '0,
  parameter logic [NW*RATIO-1:0] SRVAL_B    = '0,
  localparam int unsigned        WW         = NW * RATIO,
  localparam int unsigned        WDEPTH     = NDEPTH / RATIO,
  localparam int unsigned        AAW        = clog2(NDEPTH),
  localparam int unsigned        BAW        = clog2(WDEPTH),
  localparam int unsigned        LW         = clog2(RATIO)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ena,
  input  logic             wea,
  input  logic             ssra,
  input  logic [AAW-1:0]   addra,
  input  logic [NW-1:0]    dia,
  output logic [NW-1:0]    doa,
  input  logic             enb,
  input  logic [RATIO-1:0] web,
  input  logic             ssrb,
  input  logic [BAW-1:0]   addrb,
  input  logic [WW-1:0]    dib,
  output logic [WW-1:0]    dob,
  output logic             collision
);

  localparam int unsigned LWS = (LW == 0) ? 1 : LW;

  logic [BAW-1:0]   worda;
  logic [LWS-1:0]   lanea;
  logic [WW-1:0]    mem [WDEPTH];
  logic [WW-1:0]    rdwa, rdwb;
  logic [7:0]       a_oh8;
  logic [RATIO-1:0] a_oh;
  logic [RATIO-1:0] b_we;
  logic             a_we;
  logic             same_word;
  logic [NW-1:0]    a_old, a_new;
  logic             col_now, col_q;

  // Narrow address splits into word and little-endian lane.
  if (LW == 0) begin : g_nolane
    assign worda = addra;
    assign lanea = '0;
  end else begin : g_lane
    assign worda = addra[AAW-1:LW];
    assign lanea = addra[LW-1:0];
  end

  assign rdwa      = mem[worda];
  assign rdwb      = mem[addrb];
  assign a_we      = ena & wea;
  assign b_we      = {RATIO{enb}} & web;
  assign same_word = (worda == addrb);

  // Lane decode and port A data views; port B's lane overrides on conflict.
  always_comb begin
    a_oh8 = lane_onehot(32'(lanea));
    a_oh  = a_oh8[RATIO-1:0];
    a_old = rdwa[lanea*NW +: NW];
    a_new = (same_word && b_we[lanea]) ? dib[lanea*NW +: NW] : dia;
  end

  // Storage writes; B is issued last so it wins a same-lane conflict.
  // Contents are deliberately not reset, and writes are blocked during reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      if (a_we) mem[worda][lanea*NW +: NW] <= dia;
      for (int k = 0; k < RATIO; k++) begin
        if (b_we[k]) mem[addrb][k*NW +: NW] <= dib[k*NW +: NW];
      end
    end
  end

  // A writing B's port counts only B's written lanes; a pure B read touches
  // the whole word, so any A write into it conflicts.
  always_comb begin
    col_now = ena & enb & same_word & ((|web) ? |(web & a_oh) : wea);
  end

  // Collision flag, registered to line up with the first output stage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) col_q <= 1'b0;
    else        col_q <= col_now;
  end

`ifdef ASYM_DPRAM_OUTREG_EN
  logic col2_q;

  // Extra collision stage to stay aligned with the data pipeline.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) col2_q <= 1'b0;
    else        col2_q <= col_q;
  end

  assign collision = col2_q;
`else
  assign collision = col_q;
`endif

  asym_dpram_port #(
    .DW         (NW),
    .LANES      (1),
    .WRITE_MODE (WRITE_MODE),
    .SRVAL      (SRVAL_A)
  ) u_port_a (
    .clock (clock),
    .reset (reset),
    .en    (ena),
    .ssr   (ssra),
    .we    (a_we),
    .rdata (a_old),
    .wdata (a_new),
    .dout  (doa)
  );

  asym_dpram_port #(
    .DW         (NW),
    .LANES      (RATIO),
    .WRITE_MODE (WRITE_MODE),
    .SRVAL      (SRVAL_B)
  ) u_port_b (
    .clock (clock),
    .reset (reset),
    .en    (enb),
    .ssr   (ssrb),
    .we    (b_we),
    .rdata (rdwb),
    .wdata (dib),
    .dout  (dob)
  );

endmodule
